// File: rtl/instr_mem_pkg.sv
// Shared constants and types for the instruction memory access controller.
package instr_mem_pkg;

   localparam int unsigned ADDR_W_DEF = 11;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned DEPTH_DEF  = 2048;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int unsigned PORT_CORE   = 0;
   localparam int unsigned PORT_LOADER = 1;

   function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
      return addr < depth;
   endfunction

endpackage

// File: rtl/imem_rr_arbiter.sv
// Two-way round-robin arbiter; masked requesters are never granted.
module imem_rr_arbiter
   import instr_mem_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic [1:0] mask,
   output logic [1:0] gnt
);

   logic       last_grant_q;
   logic [1:0] active;

   always_comb begin
      active = req & ~mask;
      gnt    = '0;
      unique case (active)
         2'b01: gnt[PORT_CORE]   = 1'b1;
         2'b10: gnt[PORT_LOADER] = 1'b1;
         // On conflict the port that did not win last time goes first.
         2'b11: begin
            if (last_grant_q == 1'(PORT_LOADER)) gnt[PORT_CORE] = 1'b1;
            else                                 gnt[PORT_LOADER] = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'(PORT_LOADER);
      end else if (|gnt) begin
         last_grant_q <= gnt[PORT_LOADER];
      end
   end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Shares one single-port instruction RAM between core fetch and loader/debug,
// with a loader-only BOOT phase followed by round-robin RUN arbitration.
module instr_mem_ctrl
   import instr_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_done_i,
   output logic              boot_o,
   input  logic              c_req_i,
   input  logic [ADDR_W-1:0] c_addr_i,
   output logic              c_gnt_o,
   output logic              c_rvalid_o,
   output logic [DATA_W-1:0] c_rdata_o,
   output logic              c_err_o,
   input  logic              l_req_i,
   input  logic              l_we_i,
   input  logic [ADDR_W-1:0] l_addr_i,
   input  logic [DATA_W-1:0] l_wdata_i,
   output logic              l_gnt_o,
   output logic              l_rvalid_o,
   output logic [DATA_W-1:0] l_rdata_o,
   output logic              l_err_o,
   output logic              m_en_o,
   output logic              m_we_o,
   output logic [ADDR_W-1:0] m_addr_o,
   output logic [DATA_W-1:0] m_wdata_o,
   input  logic [DATA_W-1:0] m_rdata_i
);

   state_e            state_q, state_d;
   logic              boot;
   logic [1:0]        req, mask, gnt;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_ok;
   logic              c_pend_q, l_pend_q, err_q, wr_q;

   assign boot   = (state_q == ST_BOOT);
   assign boot_o = boot;

   // Requests are ignored while reset is held so the memory stays idle.
   assign req  = {l_req_i, c_req_i} & {2{rst_n}};
   assign mask = {1'b0, boot};

   imem_rr_arbiter u_arb (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req),
      .mask (mask),
      .gnt  (gnt)
   );

   assign c_gnt_o = gnt[PORT_CORE];
   assign l_gnt_o = gnt[PORT_LOADER];

   always_comb begin
      sel_addr  = l_gnt_o ? l_addr_i : c_addr_i;
      sel_ok    = in_range(32'(sel_addr), DEPTH);
      m_en_o    = (|gnt) & sel_ok;
      m_we_o    = m_en_o & l_gnt_o & l_we_i;
      m_addr_o  = sel_addr;
      m_wdata_o = l_gnt_o ? l_wdata_i : '0;
   end

   always_comb begin
      state_d = state_q;
      if (boot && load_done_i) state_d = ST_RUN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_BOOT;
         c_pend_q <= 1'b0;
         l_pend_q <= 1'b0;
         err_q    <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         c_pend_q <= c_gnt_o;
         l_pend_q <= l_gnt_o;
         err_q    <= (|gnt) & ~sel_ok;
         wr_q     <= l_gnt_o & l_we_i;
      end
   end

   always_comb begin
      c_rvalid_o = c_pend_q;
      c_err_o    = c_pend_q & err_q;
      c_rdata_o  = (c_pend_q && !err_q) ? m_rdata_i : '0;
      l_rvalid_o = l_pend_q;
      l_err_o    = l_pend_q & err_q;
      l_rdata_o  = (l_pend_q && !err_q && !wr_q) ? m_rdata_i : '0;
   end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl with a cycle-level reference model.
module tb_instr_mem_ctrl;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 2048;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              load_done_i;
   logic              boot_o;
   logic              c_req_i;
   logic [ADDR_W-1:0] c_addr_i;
   logic              c_gnt_o, c_rvalid_o, c_err_o;
   logic [DATA_W-1:0] c_rdata_o;
   logic              l_req_i, l_we_i;
   logic [ADDR_W-1:0] l_addr_i;
   logic [DATA_W-1:0] l_wdata_i;
   logic              l_gnt_o, l_rvalid_o, l_err_o;
   logic [DATA_W-1:0] l_rdata_o;
   logic              m_en_o, m_we_o;
   logic [ADDR_W-1:0] m_addr_o;
   logic [DATA_W-1:0] m_wdata_o;
   logic [DATA_W-1:0] m_rdata_i;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_mem_ctrl #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_done_i(load_done_i),
      .boot_o     (boot_o),
      .c_req_i    (c_req_i),
      .c_addr_i   (c_addr_i),
      .c_gnt_o    (c_gnt_o),
      .c_rvalid_o (c_rvalid_o),
      .c_rdata_o  (c_rdata_o),
      .c_err_o    (c_err_o),
      .l_req_i    (l_req_i),
      .l_we_i     (l_we_i),
      .l_addr_i   (l_addr_i),
      .l_wdata_i  (l_wdata_i),
      .l_gnt_o    (l_gnt_o),
      .l_rvalid_o (l_rvalid_o),
      .l_rdata_o  (l_rdata_o),
      .l_err_o    (l_err_o),
      .m_en_o     (m_en_o),
      .m_we_o     (m_we_o),
      .m_addr_o   (m_addr_o),
      .m_wdata_o  (m_wdata_o),
      .m_rdata_i  (m_rdata_i)
   );

   // Synchronous single-port RAM behind the controller.
   logic [DATA_W-1:0] ram [0:DEPTH-1];
   logic [DATA_W-1:0] ram_rd;
   initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;
   always @(posedge clk) begin
      if (m_en_o) begin
         if (m_we_o) ram[m_addr_o[10:0]] <= m_wdata_o;
         else        ram_rd <= ram[m_addr_o[10:0]];
      end
   end
   assign m_rdata_i = ram_rd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: contents, phase, last winner, next-cycle responses.
   logic [DATA_W-1:0] mmem [0:DEPTH-1];
   initial for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
   logic              m_boot = 1'b1;
   logic              m_last_loader = 1'b1;
   logic              e_cv = 1'b0, e_lv = 1'b0, e_err = 1'b0;
   logic [DATA_W-1:0] e_data = '0;

   task automatic model_step();
      logic              gc, gl, ok, wr;
      logic [ADDR_W-1:0] a;
      if (!rst_n) begin
         chk("rst_c_rvalid", 32'(c_rvalid_o), 0);
         chk("rst_l_rvalid", 32'(l_rvalid_o), 0);
         chk("rst_m_en", 32'(m_en_o), 0);
         chk("rst_m_we", 32'(m_we_o), 0);
         chk("rst_c_rdata", c_rdata_o, 0);
         chk("rst_l_rdata", l_rdata_o, 0);
         m_boot = 1'b1; m_last_loader = 1'b1;
         e_cv = 1'b0; e_lv = 1'b0; e_err = 1'b0; e_data = '0;
         return;
      end
      chk("boot", 32'(boot_o), 32'(m_boot));
      chk("c_rvalid", 32'(c_rvalid_o), 32'(e_cv));
      chk("l_rvalid", 32'(l_rvalid_o), 32'(e_lv));
      chk("c_err", 32'(c_err_o), 32'(e_cv & e_err));
      chk("l_err", 32'(l_err_o), 32'(e_lv & e_err));
      chk("c_rdata", c_rdata_o, e_cv ? e_data : 32'h0);
      chk("l_rdata", l_rdata_o, e_lv ? e_data : 32'h0);
      gc = c_req_i && !m_boot;
      gl = l_req_i;
      if (gc && gl) begin
         gc = m_last_loader;
         gl = !m_last_loader;
      end
      a  = gl ? l_addr_i : c_addr_i;
      ok = (32'(a) < DEPTH);
      wr = gl && l_we_i;
      chk("c_gnt", 32'(c_gnt_o), 32'(gc));
      chk("l_gnt", 32'(l_gnt_o), 32'(gl));
      chk("m_en", 32'(m_en_o), 32'((gc || gl) && ok));
      chk("m_we", 32'(m_we_o), 32'(wr && ok));
      if ((gc || gl) && ok) chk("m_addr", 32'(m_addr_o), 32'(a));
      if (wr && ok) chk("m_wdata", m_wdata_o, l_wdata_i);
      e_cv   = gc;
      e_lv   = gl;
      e_err  = !ok;
      e_data = (ok && !wr) ? mmem[a[10:0]] : '0;
      if (wr && ok) mmem[a[10:0]] = l_wdata_i;
      if (gc || gl) m_last_loader = gl;
      if (m_boot && load_done_i) m_boot = 1'b0;
   endtask

   initial forever begin
      @(negedge clk);
      model_step();
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; load_done_i = 1'b0;
      c_req_i = 1'b0; c_addr_i = '0;
      l_req_i = 1'b0; l_we_i = 1'b0; l_addr_i = '0; l_wdata_i = '0;
      step();
      neg();
      chk("lit_rst_boot", 32'(boot_o), 1);
      chk("lit_rst_m_en", 32'(m_en_o), 0);
      step();
      rst_n = 1'b1;

      // BOOT: loader writes while the core keeps requesting.
      step();
      c_req_i = 1'b1; c_addr_i = 12'd5;
      l_req_i = 1'b1; l_we_i = 1'b1; l_addr_i = 12'd5; l_wdata_i = 32'h0000_0013;
      neg();
      chk("lit_boot_l_gnt", 32'(l_gnt_o), 1);
      chk("lit_boot_m_we", 32'(m_we_o), 1);
      chk("lit_boot_c_gnt", 32'(c_gnt_o), 0);
      step();
      l_addr_i = 12'd1; l_wdata_i = 32'h1111_1111;
      neg();
      chk("lit_boot_l_rvalid", 32'(l_rvalid_o), 1);
      chk("lit_boot_l_rdata", l_rdata_o, 0);
      step();
      l_addr_i = 12'd2; l_wdata_i = 32'h2222_2222;
      step();
      l_req_i = 1'b0; l_we_i = 1'b0;
      neg();
      chk("lit_boot_c_gnt2", 32'(c_gnt_o), 0);
      step();
      c_req_i = 1'b0; load_done_i = 1'b1;
      step();
      load_done_i = 1'b0; c_req_i = 1'b1; c_addr_i = 12'd5;
      neg();
      chk("lit_run_boot", 32'(boot_o), 0);
      chk("lit_run_c_gnt", 32'(c_gnt_o), 1);
      step();
      c_req_i = 1'b0;
      neg();
      chk("lit_run_c_rvalid", 32'(c_rvalid_o), 1);
      chk("lit_run_c_rdata", c_rdata_o, 32'h0000_0013);
      chk("lit_run_c_err", 32'(c_err_o), 0);

      // Loader read alone so the next conflict goes to the core.
      step();
      l_req_i = 1'b1; l_we_i = 1'b0; l_addr_i = 12'd0;
      step();
      c_req_i = 1'b1; c_addr_i = 12'd1; l_addr_i = 12'd2;
      neg();
      chk("lit_rr0_c_gnt", 32'(c_gnt_o), 1);
      chk("lit_rr0_l_gnt", 32'(l_gnt_o), 0);
      step();
      neg();
      chk("lit_rr1_l_gnt", 32'(l_gnt_o), 1);
      chk("lit_rr1_c_rdata", c_rdata_o, 32'h1111_1111);
      step();
      neg();
      chk("lit_rr2_c_gnt", 32'(c_gnt_o), 1);
      chk("lit_rr2_l_rdata", l_rdata_o, 32'h2222_2222);
      step();
      neg();
      chk("lit_rr3_l_gnt", 32'(l_gnt_o), 1);
      chk("lit_rr3_c_rvalid", 32'(c_rvalid_o), 1);
      step();
      c_req_i = 1'b0; l_req_i = 1'b0;
      neg();
      chk("lit_rr4_l_rvalid", 32'(l_rvalid_o), 1);

      // Out of range core read.
      step();
      c_req_i = 1'b1; c_addr_i = 12'd2048;
      neg();
      chk("lit_oor_c_gnt", 32'(c_gnt_o), 1);
      chk("lit_oor_m_en", 32'(m_en_o), 0);
      step();
      c_req_i = 1'b0;
      neg();
      chk("lit_oor_c_rvalid", 32'(c_rvalid_o), 1);
      chk("lit_oor_c_err", 32'(c_err_o), 1);
      chk("lit_oor_c_rdata", c_rdata_o, 0);

      // Reset right after a core grant drops the response.
      step();
      c_req_i = 1'b1; c_addr_i = 12'd5;
      step();
      c_req_i = 1'b0; rst_n = 1'b0;
      #1;
      chk("lit_arst_c_rvalid", 32'(c_rvalid_o), 0);
      step();
      rst_n = 1'b1;
      neg();
      chk("lit_arst_boot", 32'(boot_o), 1);
      chk("lit_arst_stale", 32'(c_rvalid_o), 0);

      // Loader write granted with load_done; core follows in the first RUN cycle.
      step();
      l_req_i = 1'b1; l_we_i = 1'b1; l_addr_i = 12'd7; l_wdata_i = 32'hDEAD_BEEF;
      c_req_i = 1'b1; c_addr_i = 12'd7; load_done_i = 1'b1;
      neg();
      chk("lit_ld_l_gnt", 32'(l_gnt_o), 1);
      chk("lit_ld_c_gnt", 32'(c_gnt_o), 0);
      step();
      l_req_i = 1'b0; l_we_i = 1'b0; load_done_i = 1'b0;
      neg();
      chk("lit_ld_l_rvalid", 32'(l_rvalid_o), 1);
      chk("lit_ld_c_gnt2", 32'(c_gnt_o), 1);
      chk("lit_ld_boot", 32'(boot_o), 0);
      step();
      c_req_i = 1'b0;
      neg();
      chk("lit_ld_c_rdata", c_rdata_o, 32'hDEAD_BEEF);
      step();
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
Access controller for the instruction memory. It shares one synchronous single-port instruction RAM between two requesters: the core fetch port (read-only) and the program loader/debug port (read/write).
- Sequences a BOOT phase: the loader fills the RAM while core fetch is held off.
- Then a RUN phase with round-robin arbitration between the two ports.
- Both requester ports use a req/gnt/rvalid handshake. Out-of-range addresses are reported as errors.

Parameters:
ADDR_W, 11, word-address width of both requester ports and the memory port
DATA_W, 32, instruction/data word width
DEPTH, 2048, number of valid words; addresses >= DEPTH are out of range

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
load_done_i  in  1  one-cycle pulse from loader; ends BOOT
boot_o  out  1  1 while in BOOT state
c_req_i  in  1  core fetch request
c_addr_i  in  ADDR_W  core word address
c_gnt_o  out  1  core request accepted this cycle
c_rvalid_o  out  1  core read data valid
c_rdata_o  out  DATA_W  core read data
c_err_o  out  1  core access was out of range (valid with c_rvalid_o)
l_req_i  in  1  loader request
l_we_i  in  1  loader write enable (1 = write)
l_addr_i  in  ADDR_W  loader word address
l_wdata_i  in  DATA_W  loader write data
l_gnt_o  out  1  loader request accepted this cycle
l_rvalid_o  out  1  loader response valid (read data or write acknowledge)
l_rdata_o  out  DATA_W  loader read data
l_err_o  out  1  loader access was out of range
m_en_o  out  1  memory access enable
m_we_o  out  1  memory write enable
m_addr_o  out  ADDR_W  memory address
m_wdata_o  out  DATA_W  memory write data
m_rdata_i  in  DATA_W  memory read data, valid 1 cycle after m_en_o && !m_we_o

Behaviour:
- Reset (async, rst_n=0):
  - state=BOOT; last_grant=LOADER.
  - Both rvalid and both err flags are 0; pending-response tag is cleared.
  - All rdata outputs are 0.
  - m_en_o=0 and m_we_o=0.
- Reset mid-transaction drops the pending response; no rvalid follows the deassertion of reset.
- State machine:
  - BOOT -> RUN on load_done_i=1.
  - RUN has no exit except reset.
  - load_done_i in RUN is ignored.
- BOOT:
  - Only the loader is arbitrated; c_gnt_o=0 regardless of c_req_i.
  - Loader reads and writes are both permitted.
- RUN:
  - If only one port requests, that port is granted.
  - If both request, the port not in last_grant is granted.
  - last_grant updates on every grant.
  - The first conflict after reset is therefore won by the core.
- Grant timing:
  - gnt is combinational in the same cycle as req; at most one gnt per cycle.
  - The memory access is issued that cycle: m_addr_o/m_we_o/m_wdata_o come from the granted port and m_en_o=1.
  - Core accesses drive m_we_o=0.
- Response timing:
  - rvalid is asserted for exactly one cycle, the cycle after gnt, on the granted port only.
  - One transaction per port per cycle; back-to-back grants to the same port give back-to-back rvalids.
- Read data:
  - rdata = m_rdata_i while that port's rvalid=1, else 0.
  - Loader write: l_rvalid_o=1 with l_rdata_o=0.
- Out of range (addr >= DEPTH):
  - The request is granted, with m_en_o=0.
  - rvalid is asserted next cycle with err=1 and rdata=0. No memory write occurs.
- Requesters hold req and addr (and we/wdata) stable until gnt. Dropping req before gnt is legal; no grant is recorded.
- A loader transaction granted in the same cycle load_done_i is pulsed still completes: rvalid arrives in the first RUN cycle, and the core may be granted in that same cycle.
- No idle cycles are inserted: with both ports requesting continuously, grants alternate every cycle.

Decomposition:
- Package instr_mem_pkg holds:
  - ADDR_W, DATA_W and DEPTH defaults;
  - the state enum {ST_BOOT, ST_RUN};
  - port id constants PORT_CORE=0 and PORT_LOADER=1.
- One sub-module, imem_rr_arbiter: 2-way round-robin with a mask input (core masked in BOOT), a one-hot gnt output and a last_grant register.
- Response tag/err pipeline registers stay in the top module.

Test Plan:
- Reset, then in BOOT: loader writes 0x00000013 to addr 5 while c_req_i=1 is held → l_gnt_o=1 and m_we_o=1 that cycle; l_rvalid_o=1 next cycle; c_gnt_o stays 0 throughout BOOT.
- Pulse load_done_i, then core reads addr 5 → boot_o=0; c_gnt_o=1 same cycle; c_rvalid_o=1 next cycle with c_rdata_o=0x00000013 and c_err_o=0.
- In RUN, hold c_req_i and l_req_i high (reads of addrs 1 and 2) for 4 cycles → grants in order core, loader, core, loader; each port sees rvalid one cycle after its grant.
- Core read of addr 2048 with DEPTH=2048 → c_gnt_o=1 and m_en_o=0; next cycle c_rvalid_o=1, c_err_o=1, c_rdata_o=0.
- Assert rst_n=0 in the cycle after a core grant → c_rvalid_o=0 immediately (async); after release, state is BOOT and no stale rvalid appears.
- Loader write granted in the same cycle as the load_done_i pulse, with c_req_i=1 → l_rvalid_o=1 in the next cycle and c_gnt_o=1 in that same cycle.
